// File: rtl/tile_scroll_ctrl.sv
// Tile scroller: moves six lane rows down one pixel offset per frame step, requests one draw
// pass per step, judges key presses against the bottom row and keeps a saturating hit score.
module tile_scroll_ctrl #(
  parameter int         NUM_ROWS  = 6,
  parameter int         ROW_PITCH = 40,
  parameter int         SPEED     = 1,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    startn,
  input  logic                    frame_tick,
  input  logic [3:0]              key_lane,
  input  logic                    draw_done,
  output logic                    draw_go,
  output logic [5:0]              offset,
  output logic [5:0]              prev_offset,
  output logic [3*NUM_ROWS-1:0]   row_lanes,
  output logic [7:0]              score,
  output logic                    game_over,
  output logic [2:0]              fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_REQ  = 3'd2,
    S_REL  = 3'd3,
    S_UPD  = 3'd4,
    S_OVER = 3'd5
  } state_t;

  localparam logic [6:0] PITCH7 = 7'(ROW_PITCH);
  localparam logic [6:0] SPEED7 = 7'(SPEED);

  state_t                     state;
  logic [7:0]                 lfsr;
  logic [7:0]                 lfsr_next;
  logic [2:0]                 pend;
  logic [NUM_ROWS-1:0][2:0]   rows;

  logic [2:0] key_code;
  logic [2:0] bottom_after;
  logic [2:0] spawn;
  logic [6:0] sum;
  logic [6:0] wrapped;
  logic       hit;
  logic       wrong;
  logic       wrap;
  logic       miss;
  logic       key_window;

  assign row_lanes = rows;
  assign fsm_state = state;

  // Galois form of x^8+x^6+x^5+x^4+1, shifting right.
  always_comb begin
    lfsr_next = {1'b0, lfsr[7:1]};
    if (lfsr[0]) lfsr_next = lfsr_next ^ 8'hB8;
  end

  always_comb begin
    key_code = 3'd0;
    case (key_lane)
      4'b0001: key_code = 3'd1;
      4'b0010: key_code = 3'd2;
      4'b0100: key_code = 3'd3;
      4'b1000: key_code = 3'd4;
      default: key_code = 3'd0;
    endcase
  end

  always_comb begin
    hit          = (pend != 3'd0) && (rows[NUM_ROWS-1] == pend);
    wrong        = (pend != 3'd0) && !hit;
    bottom_after = hit ? 3'd0 : rows[NUM_ROWS-1];
    sum          = {1'b0, offset} + SPEED7;
    wrapped      = sum - PITCH7;
    wrap         = (sum >= PITCH7);
    miss         = wrap && (bottom_after != 3'd0);
    spawn        = {1'b0, lfsr[1:0]} + 3'd1;
    key_window   = (state == S_WAIT) || (state == S_REQ) || (state == S_REL);
  end

  // draw_go/draw_done handshake: draw_go rises with entry to REQ and stays high until
  // draw_done is seen high; the next step waits for draw_done to return low first.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= S_IDLE;
      lfsr        <= LFSR_SEED;
      pend        <= 3'd0;
      rows        <= '0;
      offset      <= 6'd0;
      prev_offset <= 6'd0;
      score       <= 8'd0;
      draw_go     <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      lfsr <= lfsr_next;

      if (state == S_UPD)
        pend <= key_code;
      else if (key_window && key_code != 3'd0)
        pend <= key_code;

      case (state)
        S_IDLE: begin
          if (!startn) state <= S_WAIT;
        end
        S_WAIT: begin
          if (frame_tick) begin
            state   <= S_REQ;
            draw_go <= 1'b1;
          end
        end
        S_REQ: begin
          if (draw_done) begin
            state   <= S_REL;
            draw_go <= 1'b0;
          end
        end
        S_REL: begin
          if (!draw_done) state <= S_UPD;
        end
        S_UPD: begin
          if (hit) begin
            rows[NUM_ROWS-1] <= 3'd0;
            score            <= (score == 8'hFF) ? score : score + 8'd1;
          end
          prev_offset <= offset;
          offset      <= wrap ? wrapped[5:0] : sum[5:0];
          // Shift comes after the hit clear so the incoming row wins the bottom slot.
          if (wrap && !miss) begin
            for (int i = 1; i < NUM_ROWS; i++) rows[i] <= rows[i-1];
            rows[0] <= spawn;
          end
          if (wrong || miss) begin
            state     <= S_OVER;
            game_over <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end
        S_OVER: begin
          if (!startn) begin
            state       <= S_IDLE;
            game_over   <= 1'b0;
            pend        <= 3'd0;
            rows        <= '0;
            offset      <= 6'd0;
            prev_offset <= 6'd0;
            score       <= 8'd0;
          end
        end
        default: begin
          state   <= S_IDLE;
          draw_go <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_scroll_ctrl.sv
// Bench for tile_scroll_ctrl: directed game steps, a spec-level model feeding an expected
// queue, and a monitor that checks the outputs after every update cycle.
module tb_tile_scroll_ctrl;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_UPD  = 3'd4;
  localparam logic [2:0] ST_OVER = 3'd5;

  logic        clock = 1'b0;
  logic        resetn, startn, frame_tick, draw_done;
  logic [3:0]  key_lane;
  logic        draw_go, game_over;
  logic [5:0]  offset, prev_offset;
  logic [17:0] row_lanes;
  logic [7:0]  score;
  logic [2:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  int rise_cnt = 0;
  logic [38:0] exp_q[$];

  // Reference model state
  logic [7:0]      m_lfsr;
  int              m_off, m_prev, m_score;
  logic [5:0][2:0] m_rows;
  bit              m_over;

  // Monitor state
  logic [2:0]  last_state = ST_IDLE;
  logic        last_go = 1'b0;
  logic [38:0] exp_rec;

  always #5 clock = ~clock;

  tile_scroll_ctrl #(
    .NUM_ROWS(6), .ROW_PITCH(40), .SPEED(1), .LFSR_SEED(8'hA5)
  ) dut (
    .clock(clock), .resetn(resetn), .startn(startn), .frame_tick(frame_tick),
    .key_lane(key_lane), .draw_done(draw_done), .draw_go(draw_go), .offset(offset),
    .prev_offset(prev_offset), .row_lanes(row_lanes), .score(score),
    .game_over(game_over), .fsm_state(fsm_state)
  );

  // Free-running copy of the x^8+x^6+x^5+x^4+1 Galois sequence.
  always @(posedge clock) begin
    if (!resetn) m_lfsr <= 8'hA5;
    else         m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 8'hB8) : (m_lfsr >> 1);
  end

  function automatic logic [38:0] dut_rec();
    return {offset, prev_offset, row_lanes, score, game_over};
  endfunction

  function automatic logic [38:0] model_rec();
    logic [5:0] o = 6'(m_off);
    logic [5:0] p = 6'(m_prev);
    logic [7:0] s = 8'(m_score);
    return {o, p, m_rows, s, m_over};
  endfunction

  function automatic logic [2:0] lane_code(input logic [3:0] k);
    case (k)
      4'b0001: return 3'd1;
      4'b0010: return 3'd2;
      4'b0100: return 3'd3;
      4'b1000: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] lane_key(input logic [2:0] c);
    case (c)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0010;
      3'd3:    return 4'b0100;
      3'd4:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_off = 0; m_prev = 0; m_score = 0; m_rows = '0; m_over = 1'b0;
  endtask

  // Monitor: after each update cycle, pop one expected record and compare.
  initial begin
    forever begin
      @(negedge clock);
      if (draw_go && !last_go) rise_cnt++;
      if (last_state == ST_UPD && fsm_state != ST_UPD) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_update: got %0h expected no update", dut_rec());
        end else begin
          exp_rec = exp_q.pop_front();
          check("update_rec", 64'(dut_rec()), 64'(exp_rec));
          check("update_state", 64'(fsm_state), exp_rec[0] ? 64'(ST_OVER) : 64'(ST_WAIT));
        end
      end
      last_state = fsm_state;
      last_go    = draw_go;
    end
  end

  // One full frame step from WAIT; key pressed together with the tick. Called at a negedge.
  task automatic step(input logic [3:0] key, input int hold);
    logic [2:0] p;
    bit hit, wrong, miss;
    frame_tick = 1'b1;
    key_lane   = key;
    @(posedge clock); @(negedge clock);
    frame_tick = 1'b0;
    key_lane   = 4'b0000;
    check("draw_go_req", 64'(draw_go), 64'd1);
    for (int i = 0; i < hold; i++) begin
      frame_tick = (i == hold / 2);
      @(posedge clock); @(negedge clock);
      check("hold_draw_go", 64'(draw_go), 64'd1);
      check("hold_offset", 64'(offset), 64'(m_off));
    end
    frame_tick = 1'b0;
    draw_done  = 1'b1;
    @(posedge clock); @(negedge clock);
    check("draw_go_rel", 64'(draw_go), 64'd0);
    draw_done = 1'b0;
    @(posedge clock); @(negedge clock);
    // Now in the update cycle: m_lfsr holds the value the spawn uses.
    p     = lane_code(key);
    hit   = (p != 3'd0) && (m_rows[5] == p);
    wrong = (p != 3'd0) && !hit;
    miss  = 1'b0;
    if (hit) begin
      m_rows[5] = 3'd0;
      if (m_score < 255) m_score++;
    end
    m_prev = m_off;
    if (m_off + 1 < 40) begin
      m_off = m_off + 1;
    end else begin
      m_off = m_off + 1 - 40;
      if (m_rows[5] != 3'd0) miss = 1'b1;
      else begin
        for (int i = 5; i >= 1; i--) m_rows[i] = m_rows[i-1];
        m_rows[0] = {1'b0, m_lfsr[1:0]} + 3'd1;
      end
    end
    m_over = wrong || miss;
    exp_q.push_back(model_rec());
    @(posedge clock); @(negedge clock);
  endtask

  task automatic pulse_start();
    startn = 1'b0;
    @(posedge clock); @(negedge clock);
    startn = 1'b1;
  endtask

  initial begin
    int r0, hits, guard;
    bit mh_done;
    resetn = 1'b0; startn = 1'b1; frame_tick = 1'b0; key_lane = 4'b0000; draw_done = 1'b0;
    model_clear();
    repeat (3) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    check("reset_rec", 64'(dut_rec()), 64'd0);
    check("reset_draw_go", 64'(draw_go), 64'd0);
    check("reset_state", 64'(fsm_state), 64'(ST_IDLE));

    // 1: forty plain steps, offset walks 1..39,0 and a row spawns on the wrap.
    pulse_start();
    check("start_state", 64'(fsm_state), 64'(ST_WAIT));
    r0 = rise_cnt;
    for (int i = 0; i < 40; i++) step(4'b0000, 0);
    check("draw_go_rises", 64'(rise_cnt - r0), 64'd40);
    check("row0_range", 64'(row_lanes[2:0] >= 3'd1 && row_lanes[2:0] <= 3'd4), 64'd1);
    check("wrap_offset", 64'(offset), 64'd0);

    // 2: long draw pass with a stray tick inside it; exactly one advance, no queued tick.
    step(4'b0000, 100);
    repeat (3) begin
      @(posedge clock); @(negedge clock);
      check("no_queued_tick", 64'(draw_go), 64'd0);
    end
    check("step_after_hold", 64'(offset), 64'd1);
    check("prev_after_hold", 64'(prev_offset), 64'd0);

    // 3: scroll until the first tile reaches the bottom, then hit it.
    guard = 0;
    while (m_rows[5] == 3'd0 && guard < 400) begin step(4'b0000, 0); guard++; end
    check("bottom_reached", 64'(m_rows[5] != 3'd0), 64'd1);
    step(lane_key(m_rows[5]), 0);
    check("hit_score", 64'(score), 64'd1);
    check("hit_no_over", 64'(game_over), 64'd0);

    // 4: next bottom tile, wrong lane -> game over; restart clears everything.
    guard = 0;
    while (m_rows[5] == 3'd0 && guard < 400) begin step(4'b0000, 0); guard++; end
    step(lane_key(3'((m_rows[5] % 4) + 1)), 0);
    check("wrong_over", 64'(game_over), 64'd1);
    check("wrong_score", 64'(score), 64'd1);
    pulse_start();
    check("idle_rec", 64'(dut_rec()), 64'd0);
    check("idle_state", 64'(fsm_state), 64'(ST_IDLE));
    model_clear();

    // 5: hit 256 tiles (score saturates), then let one scroll off the bottom.
    pulse_start();
    hits = 0; mh_done = 1'b0; guard = 0;
    while (!m_over && guard < 15000) begin
      if (m_rows[5] != 3'd0 && hits == 5 && !mh_done) begin
        step(4'b0011, 0);
        mh_done = 1'b1;
      end else if (m_rows[5] != 3'd0 && hits < 256) begin
        step(lane_key(m_rows[5]), 0);
        hits++;
        if (hits == 255) check("score_255", 64'(score), 64'd255);
      end else begin
        step(4'b0000, 0);
      end
      guard++;
    end
    check("miss_over", 64'(game_over), 64'd1);
    check("sat_score", 64'(score), 64'd255);
    check("miss_offset", 64'(offset), 64'd0);

    // 6: reset in the middle of a draw request.
    pulse_start();
    model_clear();
    pulse_start();
    frame_tick = 1'b1;
    @(posedge clock); @(negedge clock);
    frame_tick = 1'b0;
    check("pre_reset_go", 64'(draw_go), 64'd1);
    resetn   = 1'b0;
    key_lane = 4'b0011;
    @(posedge clock); @(negedge clock);
    check("mid_reset_go", 64'(draw_go), 64'd0);
    check("mid_reset_rec", 64'(dut_rec()), 64'd0);
    check("mid_reset_state", 64'(fsm_state), 64'(ST_IDLE));
    resetn   = 1'b1;
    key_lane = 4'b0000;
    pulse_start();
    for (int i = 0; i < 40; i++) step(4'b0000, 0);
    check("reseed_no_over", 64'(game_over), 64'd0);

    repeat (2) @(negedge clock);
    while (exp_q.size() != 0) begin
      exp_rec = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_update: got none expected %0h", exp_rec);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
